// File: rtl/kronos_if.sv
// -----------------------------------------------------------------------------
// kronos_if -- instruction fetch stage
//
// Purpose:
//   Fetches instruction words from the instruction memory and hands them to the
//   decoder as {pc, ir} pairs. The memory interface allows one outstanding read
//   at a time. The decoder interface is a valid/ready handshake, backed by a
//   registered output stage and a one-entry skid buffer. A redirect from
//   execute (branch) flushes both stages. If a read is still in flight when the
//   redirect arrives, the stage waits in DROP until that read completes, throws
//   the returned data away, and only then restarts at the new target.
//
// Parameters:
//   BOOT_ADDR      PC loaded while rstz is low
//
// Ports:
//   clk            clock, rising edge
//   rstz           asynchronous active-low reset
//   instr_addr     [31:0] out  read address (current PC)
//   instr_req      out        read request, held until instr_ack
//   instr_data     [31:0] in  read data, valid with instr_ack
//   instr_ack      in         read completion (ignored while instr_req=0)
//   fetch          out        IF/ID payload {pc, ir}
//   fetch_vld      out        payload valid
//   fetch_rdy      in         decoder accepts payload
//   branch         in         one-cycle redirect request
//   branch_target  [31:0] in  redirect PC
// -----------------------------------------------------------------------------
package kronos_if_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;
endpackage

module kronos_if
  import kronos_if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rstz,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr_data,
  input  logic        instr_ack,
  output pipeIFID_t   fetch,
  output logic        fetch_vld,
  input  logic        fetch_rdy,
  input  logic        branch,
  input  logic [31:0] branch_target
);

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;        // address of the read being requested
  logic [31:0] pc_pend;   // redirect target waiting for the dropped read to end
  pipeIFID_t   skid;
  logic        skid_vld;

  logic ack;        // a read completes this cycle
  logic handshake;  // decoder takes the output register this cycle
  logic out_free;   // output register can take new data at this edge

  assign ack        = instr_req & instr_ack;
  assign handshake  = fetch_vld & fetch_rdy;
  assign out_free   = ~fetch_vld | fetch_rdy;
  assign instr_addr = pc;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state     <= RUN;
      pc        <= BOOT_ADDR;
      pc_pend   <= BOOT_ADDR;
      instr_req <= 1'b0;
      fetch     <= '0;
      fetch_vld <= 1'b0;
      skid      <= '0;
      skid_vld  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (branch) begin
            // Redirect wins over any ack or handshake in the same cycle.
            fetch_vld <= 1'b0;
            skid_vld  <= 1'b0;
            if (instr_req && !instr_ack) begin
              // The read cannot be withdrawn: keep it on the bus and drop its data.
              pc_pend <= branch_target;
              state   <= DROP;
            end else begin
              // Nothing in flight (or it finishes now and is discarded).
              pc        <= branch_target;
              instr_req <= 1'b1;
            end
          end else if (ack) begin
            // A request is only issued while the skid buffer is empty, so an
            // ack never meets a full skid buffer.
            pc <= pc + 32'd4;
            if (out_free) begin
              fetch.pc  <= pc;
              fetch.ir  <= instr_data;
              fetch_vld <= 1'b1;
              instr_req <= 1'b1;
            end else begin
              skid.pc   <= pc;
              skid.ir   <= instr_data;
              skid_vld  <= 1'b1;
              instr_req <= 1'b0;
            end
          end else if (handshake) begin
            if (skid_vld) begin
              fetch    <= skid;
              skid_vld <= 1'b0;
            end else begin
              fetch_vld <= 1'b0;
            end
            instr_req <= 1'b1;
          end else begin
            // A pending request stays up (skid is empty while it is pending);
            // otherwise request again as soon as the skid buffer is free.
            instr_req <= ~skid_vld;
          end
        end

        DROP: begin
          // instr_req is high for the whole stay in DROP; address is frozen.
          if (ack) begin
            pc    <= branch ? branch_target : pc_pend;
            state <= RUN;
          end else if (branch) begin
            pc_pend <= branch_target;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_kronos_if.sv
// -----------------------------------------------------------------------------
// tb_kronos_if -- self-checking bench for kronos_if
//
// The reference model is the instruction stream itself: the decoder must see
// consecutive PCs starting at BOOT_ADDR (after reset) or at the last branch
// target, each carrying the word the memory holds at that PC. Protocol rules
// (request hold, flush after branch, payload stability under stall) are
// checked every cycle alongside the directed scenarios and a random phase.
// -----------------------------------------------------------------------------
module tb_kronos_if;
  import kronos_if_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstz = 1'b1;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data = '0;
  logic        instr_ack = 1'b0;
  pipeIFID_t   fetch;
  logic        fetch_vld;
  logic        fetch_rdy = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_target = '0;

  kronos_if #(.BOOT_ADDR(BOOT)) dut (
    .clk           (clk),
    .rstz          (rstz),
    .instr_addr    (instr_addr),
    .instr_req     (instr_req),
    .instr_data    (instr_data),
    .instr_ack     (instr_ack),
    .fetch         (fetch),
    .fetch_vld     (fetch_vld),
    .fetch_rdy     (fetch_rdy),
    .branch        (branch),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] exp_pc = BOOT;
  int          delivered = 0;
  logic        p_valid = 1'b0;
  logic        p_req, p_ack, p_br, p_vld, p_rdy;
  logic [31:0] p_addr;
  pipeIFID_t   p_fetch;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the outputs produced by the previous edge against
  // the rules, drive this cycle's inputs, and advance the stream model.
  task automatic cycle(input logic ack, input logic rdy, input logic br,
                       input logic [31:0] tgt, input logic dead);
    @(negedge clk);
    if (p_valid) begin
      if (p_req && !p_ack) begin
        chk("hold_req", 64'(instr_req), 64'(1'b1));
        chk("hold_addr", 64'(instr_addr), 64'(p_addr));
      end
      if (p_br) begin
        chk("branch_flush", 64'(fetch_vld), 64'(1'b0));
      end else if (p_vld && !p_rdy) begin
        chk("stall_vld", 64'(fetch_vld), 64'(1'b1));
        chk("stall_payload", fetch, p_fetch);
      end
    end
    instr_ack     = ack;
    fetch_rdy     = rdy;
    branch        = br;
    branch_target = tgt;
    instr_data    = dead ? 32'h0000_DEAD : (ack ? memfn(instr_addr) : $urandom());
    if (br) begin
      exp_pc = tgt;
    end else if (fetch_vld && rdy) begin
      chk("pc_order", 64'(fetch.pc), 64'(exp_pc));
      chk("ir_data", 64'(fetch.ir), 64'(memfn(fetch.pc)));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    p_req   = instr_req;
    p_ack   = ack;
    p_addr  = instr_addr;
    p_br    = br;
    p_vld   = fetch_vld;
    p_rdy   = rdy;
    p_fetch = fetch;
    p_valid = 1'b1;
  endtask

  // Asynchronous reset pulse starting at the current time; a pending ack is
  // held high throughout and must be ignored.
  task automatic reset_pulse();
    rstz = 1'b0;
    #1;
    chk("rst_vld", 64'(fetch_vld), 64'(1'b0));
    chk("rst_req", 64'(instr_req), 64'(1'b0));
    chk("rst_addr", 64'(instr_addr), 64'(BOOT));
    chk("rst_payload", fetch, 64'h0);
    p_valid   = 1'b0;
    exp_pc    = BOOT;
    instr_ack = 1'b1;
    fetch_rdy = 1'b0;
    branch    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold_req", 64'(instr_req), 64'(1'b0));
    chk("rst_hold_vld", 64'(fetch_vld), 64'(1'b0));
    rstz      = 1'b1;
    instr_ack = 1'b0;
    fetch_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 64'(instr_req), 64'(1'b1));
    chk("post_rst_addr", 64'(instr_addr), 64'(BOOT));
    chk("post_rst_vld", 64'(fetch_vld), 64'(1'b0));
  endtask

  initial begin
    int d0;
    logic [31:0] tgt;
    logic        a, r, b;

    // Power-on reset
    #1;
    reset_pulse();

    // Streaming: ack every cycle, decoder always ready
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("stream_first_vld", 64'(fetch_vld), 64'(1'b0));
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk("stream_pc", {31'b0, fetch_vld, fetch.pc}, {31'b0, 1'b1, BOOT + 32'(4 * k)});
    end

    // Backpressure: output + skid fill, request drops
    repeat (4) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("bp_req_low", 64'(instr_req), 64'(1'b0));
    chk("bp_vld", 64'(fetch_vld), 64'(1'b1));
    chk("bp_two_buffered", 64'(instr_addr), 64'(fetch.pc + 32'd8));
    d0 = delivered;
    repeat (4) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("bp_release_count", 64'(delivered - d0), 64'd4);

    // Branch while a read is in flight: DROP discards the late data
    cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("drop_setup_addr", 64'(instr_addr), 64'h200);
    cycle(1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
    repeat (2) begin
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("drop_hold", {31'b0, instr_req, instr_addr}, {31'b0, 1'b1, 32'h200});
    end
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("drop_next_addr", {31'b0, instr_req, instr_addr}, {31'b0, 1'b1, 32'h400});
    chk("drop_no_dead", 64'(fetch_vld), 64'(1'b0));
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("drop_resume", {31'b0, fetch_vld, fetch.pc}, {31'b0, 1'b1, 32'h400});

    // Branch with same-cycle ack
    cycle(1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
    chk("sameack_addr_before", 64'(p_addr), 64'h10);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("sameack_flush", {31'b0, fetch_vld, instr_addr}, {31'b0, 1'b0, 32'h80});
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("sameack_resume", {31'b0, fetch_vld, fetch.pc}, {31'b0, 1'b1, 32'h80});

    // PC wrap-around
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_addr_before", 64'(instr_addr), 64'hFFFF_FFFC);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_addr", 64'(instr_addr), 64'h0);
    chk("wrap_fetch", {31'b0, fetch_vld, fetch.pc}, {31'b0, 1'b1, 32'hFFFF_FFFC});

    // Reset mid-operation with output and skid full
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("skid_full_req", 64'(instr_req), 64'(1'b0));
    #2;
    reset_pulse();
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("rst_resume", {31'b0, fetch_vld, fetch.pc}, {31'b0, 1'b1, BOOT});

    // Reset with a request pending and no ack yet
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    #2;
    reset_pulse();

    // Random traffic against the stream model
    d0 = delivered;
    for (int i = 0; i < 800; i++) begin
      a = instr_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                        : (32'h1000 + {22'b0, 8'($urandom_range(0, 255)), 2'b00});
      cycle(a, r, b, tgt, 1'b0);
    end
    chk("random_progress", 64'(delivered - d0 > 100), 64'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
